atm_cell_tx: RTL and testbench

//  - Cell-to-byte transmitter for the ATM datapath; counterpart of the byte-to-cell input interface.
//  - Accepts a whole 53-byte cell in parallel, holds it in a one-cell buffer and serializes it MSB-byte-first.
//  - Sends it onto an 8-bit valid/ready link toward the PHY/line side.
//  - Back-to-back cells stream with no idle byte between them.

---
 rtl/atm_pkg.sv | 30 +++
 rtl/atm_cell_tx_if.sv | 29 ++
 rtl/atm_hec_gen.sv | 10 +
 rtl/atm_cell_tx.sv | 98 +++++++++
 tb/tb_atm_cell_tx.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/atm_pkg.sv
// Shared ATM constants, transmitter state type and the HEC helper.
// The HEC helper is only reached from atm_hec_gen (built when ATM_HEC_GEN_EN is defined).
package atm_pkg;

  localparam int          ATM_CELL_BYTES = 53;
  localparam int          ATM_HDR_BYTES  = 4;
  localparam logic [7:0]  ATM_HEC_POLY   = 8'h07;
  localparam logic [7:0]  ATM_HEC_COSET  = 8'h55;

  localparam logic [0:0]  ST_IDLE = 1'b0;
  localparam logic [0:0]  ST_SEND = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    SEND = ST_SEND
  } atm_tx_state_t;

  // CRC-8 over the header, MSB first, init 0, then the ATM coset.
  function automatic logic [7:0] atm_hec_calc(input logic [ATM_HDR_BYTES*8-1:0] hdr);
    logic [7:0] crc;
    logic       fb;
    crc = 8'h00;
    for (int i = ATM_HDR_BYTES*8-1; i >= 0; i--) begin
      fb  = crc[7] ^ hdr[i];
      crc = {crc[6:0], 1'b0} ^ (fb ? ATM_HEC_POLY : 8'h00);
    end
    return crc ^ ATM_HEC_COSET;
  endfunction

endpackage

// File: rtl/atm_cell_tx_if.sv
// Cell-in / byte-out handshake bundle of the ATM cell transmitter.
// master = upstream cell source plus downstream sink, slave = atm_cell_tx.
interface atm_cell_tx_if
  import atm_pkg::*;
#(
  parameter int CELL_BYTES = ATM_CELL_BYTES,
  parameter int CNT_W      = 16
);
  logic [CELL_BYTES*8-1:0] cell_in;
  logic                    cell_valid;
  logic                    cell_ready;
  logic [7:0]              data_out;
  logic                    valid_out;
  logic                    ready_in;
  logic                    sop_out;
  logic                    eop_out;
  logic                    busy;
  logic [CNT_W-1:0]        cells_sent;

  modport master (
    output cell_in, cell_valid, ready_in,
    input  cell_ready, data_out, valid_out, sop_out, eop_out, busy, cells_sent
  );

  modport slave (
    input  cell_in, cell_valid, ready_in,
    output cell_ready, data_out, valid_out, sop_out, eop_out, busy, cells_sent
  );
endinterface

// File: rtl/atm_hec_gen.sv
// Combinational ATM HEC generator: 32-bit header in, 8-bit HEC out.
// Instantiated by atm_cell_tx only when ATM_HEC_GEN_EN is defined.
module atm_hec_gen
  import atm_pkg::*;
(
  input  logic [ATM_HDR_BYTES*8-1:0] hdr,
  output logic [7:0]                 hec
);
  assign hec = atm_hec_calc(hdr);
endmodule

// File: rtl/atm_cell_tx.sv
// ATM cell-to-byte transmitter: one-cell hold buffer feeding a byte shifter.
// Define ATM_HEC_GEN_EN to overwrite byte 4 with the generated HEC at load time.
module atm_cell_tx
  import atm_pkg::*;
#(
  parameter int CELL_BYTES = ATM_CELL_BYTES,
  parameter int CNT_W      = 16
)(
  input  logic          clk,
  input  logic          rst_n,
  atm_cell_tx_if.slave  bus
);
  localparam int              CELL_W   = CELL_BYTES * 8;
  localparam int              IDX_W    = (CELL_BYTES > 1) ? $clog2(CELL_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELL_BYTES - 1);

  atm_tx_state_t     state;
  logic              hold_full;
  logic [CELL_W-1:0] hold_buf;
  logic [CELL_W-1:0] load_cell;
  logic [CELL_W-1:0] shifter;
  logic [IDX_W-1:0]  byte_idx;
  logic [CNT_W-1:0]  cells_sent;
  logic              accept;
  logic              xfer;
  logic              last_byte;
  logic              load;

  // NOTE: cell_ready comes from hold_full alone so upstream never sees a path from ready_in.
  assign bus.cell_ready = !hold_full;
  assign accept         = bus.cell_valid && !hold_full;
  assign xfer           = (state == SEND) && bus.ready_in;
  assign last_byte      = (byte_idx == LAST_IDX);
  // The held cell moves into the shifter when idle or on the final byte transfer (zero-gap chaining).
  assign load           = hold_full && ((state == IDLE) || (xfer && last_byte));

`ifdef ATM_HEC_GEN_EN
  logic [7:0] hec;

  atm_hec_gen u_hec_gen (
    .hdr (hold_buf[CELL_W-1 -: ATM_HDR_BYTES*8]),
    .hec (hec)
  );

  always_comb begin
    load_cell = hold_buf;
    load_cell[CELL_W-1-ATM_HDR_BYTES*8 -: 8] = hec;
  end
`else
  assign load_cell = hold_buf;
`endif

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold_full  <= 1'b0;
      byte_idx   <= '0;
      cells_sent <= '0;
    end else begin
      if (accept)
        hold_full <= 1'b1;
      else if (load)
        hold_full <= 1'b0;

      if (xfer && last_byte)
        cells_sent <= cells_sent + CNT_W'(1);

      if (load) begin
        state    <= SEND;
        byte_idx <= '0;
      end else if (xfer) begin
        if (last_byte)
          state <= IDLE;
        else
          byte_idx <= byte_idx + IDX_W'(1);
      end
    end
  end

  // NOTE: the cell buffers carry no reset; hold_full and state alone say whether their contents are live.
  always_ff @(posedge clk) begin
    if (accept)
      hold_buf <= bus.cell_in;
    if (load)
      shifter <= load_cell;
    else if (xfer)
      shifter <= shifter << 8;
  end

  assign bus.valid_out  = (state == SEND);
  assign bus.data_out   = bus.valid_out ? shifter[CELL_W-1 -: 8] : 8'h00;
  assign bus.sop_out    = bus.valid_out && (byte_idx == '0);
  assign bus.eop_out    = bus.valid_out && last_byte;
  assign bus.busy       = hold_full || (state == SEND);
  assign bus.cells_sent = cells_sent;

endmodule

// File: tb/tb_atm_cell_tx.sv
// Directed bench for atm_cell_tx with a byte-stream model checked every cycle,
// plus a narrow-counter instance to exercise the cells_sent wrap.
module tb_atm_cell_tx;
  import atm_pkg::*;

  localparam int CB = 53;

  logic clk;
  logic rst_n;

  atm_cell_tx_if #(.CELL_BYTES(CB), .CNT_W(16)) bus   ();
  atm_cell_tx_if #(.CELL_BYTES(CB), .CNT_W(4))  bus_w ();

  atm_cell_tx #(.CELL_BYTES(CB), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  atm_cell_tx #(.CELL_BYTES(CB), .CNT_W(4)) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] b;
    logic       sop;
    logic       eop;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp_cnt;
  int          total;
  int          bad;

`ifdef ATM_HEC_GEN_EN
  localparam logic [7:0] HEC_EXP = 8'h52;
`else
  localparam logic [7:0] HEC_EXP = 8'hAA;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // HEC as polynomial remainder of header*x^8 modulo x^8+x^2+x+1, then the coset.
  function automatic logic [7:0] ref_hec(input logic [31:0] h);
    logic [39:0] r;
    r = {h, 8'h00};
    for (int b = 39; b >= 8; b--)
      if (r[b]) r = r ^ (40'h107 << (b - 8));
    return r[7:0] ^ 8'h55;
  endfunction

  function automatic logic [CB*8-1:0] mk(input logic [7:0] base, input logic [7:0] stp);
    logic [CB*8-1:0] c;
    for (int i = 0; i < CB; i++)
      c[CB*8-1-8*i -: 8] = base + stp * 8'(i);
    return c;
  endfunction

  // Model: every accepted cell appends its bytes to the expected stream; each transfer consumes one.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_valid_out",  bus.valid_out,  1'b0);
      check("rst_cell_ready", bus.cell_ready, 1'b1);
      check("rst_cells_sent", bus.cells_sent, 16'h0);
      check("rst_busy",       bus.busy,       1'b0);
      check("rst_data_out",   bus.data_out,   8'h00);
      check("rst_sop_eop",    {bus.sop_out, bus.eop_out}, 2'b00);
      exp_q.delete();
      exp_cnt = 16'h0;
    end else begin
      check("cells_sent", bus.cells_sent, exp_cnt);
      check("busy", bus.busy, exp_q.size() != 0);
      if (exp_q.size() == 0) begin
        check("valid_with_empty_model", bus.valid_out, 1'b0);
      end else if (bus.valid_out) begin
        exp_t e;
        e = exp_q[0];
        check("data_out", bus.data_out, e.b);
        check("sop_out",  bus.sop_out,  e.sop);
        check("eop_out",  bus.eop_out,  e.eop);
        if (bus.ready_in) begin
          void'(exp_q.pop_front());
          if (e.eop) exp_cnt++;
        end
      end
      if (bus.cell_valid && bus.cell_ready) begin
        for (int i = 0; i < CB; i++) begin
          exp_t n;
          n.b   = bus.cell_in[CB*8-1-8*i -: 8];
`ifdef ATM_HEC_GEN_EN
          if (i == 4) n.b = ref_hec(bus.cell_in[CB*8-1 -: 32]);
`endif
          n.sop = (i == 0);
          n.eop = (i == CB - 1);
          exp_q.push_back(n);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Presents a cell and returns 2 time units after the edge that accepted it.
  task automatic offer(input logic [CB*8-1:0] c);
    logic ok;
    int   n;
    bus.cell_in    = c;
    bus.cell_valid = 1'b1;
    n = 0;
    do begin
      ok = bus.cell_ready;
      step();
      n++;
    end while (!ok && n < 500);
    check("offer_accepted", ok, 1'b1);
    bus.cell_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!bus.valid_out && n < 500) begin
      step();
      n++;
    end
    check("wait_valid", bus.valid_out, 1'b1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus.busy || bus.valid_out) && n < 1000) begin
      step();
      n++;
    end
    check("wait_idle", bus.busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CB*8-1:0] a;
    logic [CB*8-1:0] b;
    logic [7:0]      d0;
    logic [7:0]      eop_byte;
    int              n;
    int              nsop;
    int              nlow;
    logic            prev_eop;

    total = 0;
    bad   = 0;
    exp_cnt = 16'h0;
    rst_n = 1'b1;
    bus.cell_in = '0;  bus.cell_valid = 1'b0;  bus.ready_in = 1'b1;
    bus_w.cell_in = '0; bus_w.cell_valid = 1'b0; bus_w.ready_in = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("init_cell_ready", bus.cell_ready, 1'b1);
    check("init_valid_out",  bus.valid_out,  1'b0);
    check("init_cells_sent", bus.cells_sent, 16'h0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    step();

    // 1: single cell 0x00..0x34 with ready_in held high
    offer(mk(8'h00, 8'h01));
    check("t1_busy_held",     bus.busy,       1'b1);
    check("t1_ready_low",     bus.cell_ready, 1'b0);
    check("t1_no_valid_yet",  bus.valid_out,  1'b0);
    step();
    check("t1_first_valid",   bus.valid_out,  1'b1);
    check("t1_first_sop",     bus.sop_out,    1'b1);
    check("t1_first_byte",    bus.data_out,   8'h00);
    check("t1_ready_back",    bus.cell_ready, 1'b1);
    n = 0;
    eop_byte = 8'h00;
    while (bus.valid_out && n < 200) begin
      if (bus.eop_out) eop_byte = bus.data_out;
      n++;
      step();
    end
    check("t1_valid_cycles", n, 53);
    check("t1_eop_byte",     eop_byte, 8'h34);
    check("t1_cells_sent",   bus.cells_sent, 16'd1);
    check("t1_valid_drop",   bus.valid_out, 1'b0);

    // 2: ready_in toggles every cycle, starting stalled on byte 0
    offer(mk(8'h40, 8'h03));
    wait_valid();
    bus.ready_in = 1'b0;
    n  = 0;
    d0 = 8'h00;
    while (bus.valid_out && n < 400) begin
      n++;
      if (n == 1) d0 = bus.data_out;
      if (n == 2) begin
        check("t2_stall_stable", bus.data_out, d0);
        check("t2_stall_byte0",  bus.data_out, 8'h40);
      end
      step();
      bus.ready_in = ~bus.ready_in;
    end
    bus.ready_in = 1'b1;
    check("t2_valid_cycles", n, 106);
    check("t2_cells_sent",   bus.cells_sent, 16'd2);

    // 3: two cells back to back, eop of A directly followed by sop of B
    a = mk(8'h80, 8'h01);
    b = mk(8'hC0, 8'h05);
    offer(a);
    offer(b);
    check("t3_streaming", bus.valid_out, 1'b1);
    n = 0; nsop = 0; nlow = 0; prev_eop = 1'b0;
    while (bus.valid_out && n < 400) begin
      n++;
      if (!bus.cell_ready) nlow++;
      if (bus.sop_out) begin
        nsop++;
        check("t3_sop_after_eop", prev_eop, 1'b1);
      end
      prev_eop = bus.eop_out;
      step();
    end
    check("t3_valid_cycles", n, 105);
    check("t3_sop_count",    nsop, 1);
    check("t3_ready_low",    nlow, 52);
    check("t3_cells_sent",   bus.cells_sent, 16'd4);

    // 4: header 00 00 00 01, byte 4 = 0xAA
    a = mk(8'h10, 8'h01);
    a[CB*8-1 -: 40] = 40'h00_00_00_01_AA;
    offer(a);
    wait_valid();
    repeat (4) step();
    check("t4_byte4", bus.data_out, HEC_EXP);
    wait_idle();
    check("t4_cells_sent", bus.cells_sent, 16'd5);

    // 5: reset after byte 20 with a second cell held
    offer(mk(8'h20, 8'h01));
    offer(mk(8'h60, 8'h01));
    repeat (20) step();
    check("t5_byte21",     bus.data_out, 8'h35);
    check("t5_held",       bus.cell_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t5_valid_drop", bus.valid_out,  1'b0);
    check("t5_ready_up",   bus.cell_ready, 1'b1);
    check("t5_cnt_clear",  bus.cells_sent, 16'h0);
    check("t5_busy_clear", bus.busy,       1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    offer(mk(8'hE0, 8'h07));
    wait_valid();
    check("t5_new_sop",  bus.sop_out,  1'b1);
    check("t5_new_byte", bus.data_out, 8'hE0);
    wait_idle();
    check("t5_cells_sent", bus.cells_sent, 16'd1);

    // 6: 4-bit counter instance wraps 0xF -> 0x0 on the sixteenth eop
    check("t6_start", bus_w.cells_sent, 4'h0);
    bus_w.cell_in    = mk(8'h00, 8'h01);
    bus_w.cell_valid = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 2000 && n < 16; cyc++) begin
      if (bus_w.valid_out && bus_w.eop_out) begin
        n++;
        step();
        if (n == 15) check("t6_cnt_15", bus_w.cells_sent, 4'hF);
        if (n == 16) check("t6_wrap",   bus_w.cells_sent, 4'h0);
      end else begin
        step();
      end
    end
    bus_w.cell_valid = 1'b0;
    check("t6_eops", n, 16);

    check("model_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
